// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory arbiter slice.
package lc3_pkg;

    localparam int unsigned WORD_W = 16;

    // Requester indices; also the encoding of the round-robin grant index
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/lc3_rr2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to
// the port opposite the previous winner.
module lc3_rr2
    import lc3_pkg::*;
(
    input  logic [1:0] req,     // req[PORT_CPU], req[PORT_DBG]
    input  logic       last,    // previous winner
    output logic       gnt_idx,
    output logic       valid
);

    // Pick the winning port index
    always_comb begin
        valid   = |req;
        gnt_idx = PORT_CPU;
        unique case (req)
            2'b01:   gnt_idx = PORT_CPU;
            2'b10:   gnt_idx = PORT_DBG;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Arbitrates a single-ported memory between the CPU and a debug/loader port.
// One transaction at a time: IDLE -> ACCESS (MEM_LAT cycles) -> DONE.
module lc3_mem_arbiter
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = WORD_W
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_done,
    output logic [DW-1:0] dbg_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          win_q, win_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic rr_idx;
    logic rr_valid;
    logic in_access;

    lc3_rr2 u_rr2 (
        .req     ({dbg_req, cpu_req}),
        .last    (last_q),
        .gnt_idx (rr_idx),
        .valid   (rr_valid)
    );

    // State and transaction registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            win_q       <= PORT_CPU;
            last_q      <= PORT_DBG;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Next-state: grant in IDLE, count down in ACCESS, one DONE cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    state_d = ACCESS;
                    cnt_d   = LAT_M1;
                    win_d   = rr_idx;
                    last_d  = rr_idx;
                    if (rr_idx == PORT_CPU) begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (win_q == PORT_CPU) cpu_rdata_d = mem_rdata;
                        else                   dbg_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them at once
    always_comb begin
        in_access = (state_q == ACCESS);
        // Counter starts at LAT_M1 and only counts down, so this marks the first cycle
        cpu_gnt   = in_access && (cnt_q == LAT_M1) && (win_q == PORT_CPU);
        dbg_gnt   = in_access && (cnt_q == LAT_M1) && (win_q == PORT_DBG);
        cpu_done  = (state_q == DONE) && (win_q == PORT_CPU);
        dbg_done  = (state_q == DONE) && (win_q == PORT_DBG);
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        mem_en    = in_access;
        mem_we    = in_access && we_q;
        mem_addr  = in_access ? addr_q : '0;
        mem_wdata = in_access ? wdata_q : '0;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: a MEM_LAT=2 instance for most cases and
// a MEM_LAT=1 instance for the single-cycle latency boundary.
module tb_lc3_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // MEM_LAT=2 instance
    logic        cpu_req = 0, cpu_we = 0, cpu_gnt, cpu_done;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
    logic        dbg_req = 0, dbg_we = 0, dbg_gnt, dbg_done;
    logic [15:0] dbg_addr = 0, dbg_wdata = 0, dbg_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    // MEM_LAT=1 instance
    logic        c1_req = 0, c1_gnt, c1_done;
    logic [15:0] c1_addr = 0, c1_rdata;
    logic        d1_gnt, d1_done;
    logic [15:0] d1_rdata;
    logic        m1_en, m1_we, busy1;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Memory contents: x3000 holds x1234, everything else is addr ^ xA5A5
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    assign mem_rdata = mem_model(mem_addr);
    assign m1_rdata  = mem_model(m1_addr);

    lc3_mem_arbiter #(.MEM_LAT(2), .AW(16), .DW(16)) u_dut (
        .clk (clk), .reset (reset),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
        .cpu_gnt (cpu_gnt), .cpu_done (cpu_done), .cpu_rdata (cpu_rdata),
        .dbg_req (dbg_req), .dbg_we (dbg_we), .dbg_addr (dbg_addr), .dbg_wdata (dbg_wdata),
        .dbg_gnt (dbg_gnt), .dbg_done (dbg_done), .dbg_rdata (dbg_rdata),
        .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .busy (busy)
    );

    lc3_mem_arbiter #(.MEM_LAT(1), .AW(16), .DW(16)) u_dut1 (
        .clk (clk), .reset (reset),
        .cpu_req (c1_req), .cpu_we (1'b0), .cpu_addr (c1_addr), .cpu_wdata (16'h0000),
        .cpu_gnt (c1_gnt), .cpu_done (c1_done), .cpu_rdata (c1_rdata),
        .dbg_req (1'b0), .dbg_we (1'b0), .dbg_addr (16'h0000), .dbg_wdata (16'h0000),
        .dbg_gnt (d1_gnt), .dbg_done (d1_done), .dbg_rdata (d1_rdata),
        .mem_en (m1_en), .mem_we (m1_we), .mem_addr (m1_addr), .mem_wdata (m1_wdata),
        .mem_rdata (m1_rdata), .busy (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int ngnt;
        int both;

        // Outputs are all zero while reset is held
        #1;
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_gnt", {cpu_gnt, dbg_gnt}, 0);
        check("rst_done", {cpu_done, dbg_done}, 0);
        check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        do_reset();

        // CPU read of x3000 alone
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        step();                                         // T+1
        check("rd_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
        check("rd_en1", mem_en, 1);
        check("rd_addr1", mem_addr, 16'h3000);
        check("rd_busy", busy, 1);
        cpu_req = 0; cpu_addr = 16'hFFFF;
        step();                                         // T+2
        check("rd_gnt_once", cpu_gnt, 0);
        check("rd_en2", mem_en, 1);
        check("rd_addr2", mem_addr, 16'h3000);
        check("rd_early_done", cpu_done, 0);
        step();                                         // T+3
        check("rd_done", {cpu_done, dbg_done}, 2'b10);
        check("rd_rdata", cpu_rdata, 16'h1234);
        check("rd_en_off", mem_en, 0);
        step();                                         // T+4
        check("rd_done_once", cpu_done, 0);
        check("rd_idle", busy, 0);
        check("rd_hold", cpu_rdata, 16'h1234);

        // Tie straight after reset: CPU first, DBG four cycles later
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h3002;
        step();                                         // T+1
        check("tie_gnt1", {cpu_gnt, dbg_gnt}, 2'b10);
        cpu_req = 0;
        step();                                         // T+2
        step();                                         // T+3
        check("tie_cpu_done", {cpu_done, dbg_done}, 2'b10);
        step();                                         // T+4
        check("tie_wait", {cpu_gnt, dbg_gnt, busy}, 3'b000);
        step();                                         // T+5
        check("tie_gnt2", {cpu_gnt, dbg_gnt}, 2'b01);
        check("tie_addr", mem_addr, 16'h3002);
        dbg_req = 0;
        step();                                         // T+6
        check("tie_no_early", dbg_done, 0);
        step();                                         // T+7
        check("tie_dbg_done", {cpu_done, dbg_done}, 2'b01);
        check("tie_dbg_rdata", dbg_rdata, 16'h95A7);
        step();                                         // idle

        // DBG write x0042 to x3001; operands change after the grant
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h3001; dbg_wdata = 16'h0042;
        step();
        check("wr_gnt", {cpu_gnt, dbg_gnt}, 2'b01);
        check("wr_mem1", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h3001, 16'h0042});
        dbg_req = 0; dbg_we = 0; dbg_addr = 16'hFFFF; dbg_wdata = 16'hFFFF;
        step();
        check("wr_mem2", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h3001, 16'h0042});
        step();
        check("wr_done", {dbg_done, mem_we, mem_en}, 3'b100);
        check("wr_rdata_kept", dbg_rdata, 16'h95A7);
        step();

        // Both hold requests: grants must alternate, starting with CPU
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h3002;
        ngnt = 0;
        both = 0;
        for (int cyc = 0; cyc < 40 && ngnt < 6; cyc++) begin
            step();
            if (cpu_gnt && dbg_gnt) both++;
            if (cpu_done && dbg_done) both++;
            if (cpu_gnt || dbg_gnt) begin
                check("rr_order", dbg_gnt, ngnt % 2);
                ngnt++;
            end
        end
        check("rr_count", ngnt, 6);
        check("rr_both", both, 0);
        cpu_req = 0; dbg_req = 0;
        step(); step(); step();
        check("rr_idle", busy, 0);

        // Reset in the second ACCESS cycle abandons the read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        step();
        check("ab_gnt", cpu_gnt, 1);
        cpu_req = 0;
        step();
        check("ab_en_pre", mem_en, 1);
        reset = 1;
        #1;
        check("ab_en_drop", {mem_en, busy}, 2'b00);
        check("ab_rdata", cpu_rdata, 0);
        @(posedge clk);
        #1;
        reset = 0;
        step();
        check("ab_no_done", {cpu_done, dbg_done, busy}, 3'b000);
        cpu_req = 1; cpu_addr = 16'h3002;
        step();
        check("ab_gnt2", cpu_gnt, 1);
        cpu_req = 0;
        step();
        step();
        check("ab_done2", cpu_done, 1);
        check("ab_rdata2", cpu_rdata, 16'h95A7);

        // MEM_LAT=1: one-cycle pulse request, single ACCESS cycle
        step();
        c1_req = 1; c1_addr = 16'h3000;
        step();
        check("l1_gnt", {c1_gnt, m1_en}, 2'b11);
        c1_req = 0;
        step();
        check("l1_done", {c1_done, m1_en}, 2'b10);
        check("l1_rdata", c1_rdata, 16'h1234);
        step();
        check("l1_idle", {c1_done, c1_gnt, busy1}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access latency in cycles; legal range 1..15.
REQ-002 Parameter AW, default 16, address width.
REQ-003 Parameter DW, default 16, data width.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port cpu_req  input  1  CPU access request, held until cpu_gnt.
REQ-007 Port cpu_we  input  1  CPU write (1) or read (0).
REQ-008 Port cpu_addr  input  AW  CPU address.
REQ-009 Port cpu_wdata  input  DW  CPU write data.
REQ-010 Port cpu_gnt  output  1  one-cycle grant pulse to CPU.
REQ-011 Port cpu_done  output  1  one-cycle completion pulse to CPU.
REQ-012 Port cpu_rdata  output  DW  CPU read data, valid with cpu_done.
REQ-013 Ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata SHALL mirror REQ-006..012 for the debug/loader requester.
REQ-014 Port mem_en  output  1  memory enable.
REQ-015 Port mem_we  output  1  memory write enable.
REQ-016 Port mem_addr  output  AW  memory address.
REQ-017 Port mem_wdata  output  DW  memory write data.
REQ-018 Port mem_rdata  input  DW  memory read data, valid in last access cycle.
REQ-019 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM SHALL have states IDLE, ACCESS, DONE; one transaction in flight at most.
REQ-021 In IDLE, requests sampled each edge; only one asserted -> that port wins; none -> stay IDLE.
REQ-022 Both asserted in IDLE -> winner is the port opposite to last_winner (round-robin); last_winner updated on every grant.
REQ-023 On grant edge: latch winner, addr, we, wdata; go ACCESS; load counter with MEM_LAT-1.
REQ-024 Winner's gnt SHALL be high exactly the first ACCESS cycle (request at cycle T -> gnt at T+1).
REQ-025 During ACCESS: mem_en=1, mem_addr/mem_wdata/mem_we driven from latched values, stable for all MEM_LAT cycles; outside ACCESS mem_en=0, mem_we=0.
REQ-026 ACCESS with counter 0: on read, capture mem_rdata into winner's rdata register; go DONE; otherwise decrement counter.
REQ-027 In DONE, winner's done=1 for one cycle; next state IDLE; done for request at T SHALL occur at T+1+MEM_LAT.
REQ-028 rdata registers SHALL hold value until next read completion on that port; writes leave them unchanged.
REQ-029 Request inputs and operands SHALL be ignored outside IDLE; requester may change them after gnt.
REQ-030 Request dropped before grant -> no access, no gnt.
REQ-031 Requests held continuously by both ports -> grants alternate CPU, DBG, CPU, ...; no starvation.
REQ-032 gnt and done SHALL never be asserted to both ports in the same cycle.

Reset
REQ-033 Reset SHALL force state IDLE, counter 0, last_winner=DBG (so CPU wins first tie), rdata registers 0.
REQ-034 During reset all outputs SHALL be 0, immediately (asynchronous).
REQ-035 Reset mid-ACCESS SHALL abandon the transaction: no done pulse, mem_en drops at once.

Structure
REQ-036 Shared package lc3_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), port-select constants (PORT_CPU, PORT_DBG), and 16-bit word width.
REQ-037 Two-way round-robin selection SHALL be a sub-module lc3_rr2 (inputs req[1:0], last; outputs grant index, valid).

Verification
REQ-038 CPU read x3000 alone, MEM_LAT=2, memory returns x1234 -> cpu_gnt at T+1, mem_en T+1..T+2, cpu_done at T+3 with cpu_rdata=x1234.
REQ-039 Both request at T after reset -> CPU granted T+1, DBG granted T+5; DBG done at T+7.
REQ-040 DBG write x0042 to x3001 -> mem_we=1, mem_addr=x3001, mem_wdata=x0042 both ACCESS cycles; dbg_rdata unchanged.
REQ-041 Both hold req for 6 transactions -> grant order CPU,DBG,CPU,DBG,CPU,DBG, never simultaneous.
REQ-042 Reset asserted in 2nd ACCESS cycle -> mem_en=0 same cycle, no done; after release, fresh CPU read completes normally.
REQ-043 MEM_LAT=1, CPU req pulsed T then dropped T+1 -> gnt T+1, done T+2; single mem_en cycle.
